spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
Serial shift stage directly downstream of the SPI master control FSM. It consumes the internal mode-adjusted serial clock, the load strobe, the bit-order-adjusted transmit word and the length code. It drives MOSI, assembles MISO into a receive word, and returns done plus the receive-load strobe to the control FSM. All logic runs on clk_cpu; SCK_inter is treated as a sampled data signal, never as a clock.

Parameters:
DATA_WIDTH, 32, width of transmit/receive words
CNT_W, 6, bit-counter width (must hold DATA_WIDTH)

Ports:
clk_cpu  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
SCK_inter  in  1  mode-adjusted serial clock from control; sampled on clk_cpu
load_data  in  1  transfer request level from control
NEW_SPI_DATA_OUT  in  DATA_WIDTH  transmit word, already bit-order adjusted
SPI_DATA_LEN  in  2  length code: 00=8, 01=16, 10=24, 11=32 bits
MISO  in  1  serial input from slave
MOSI  out  1  serial output to slave
done  out  1  one-cycle pulse at end of transfer
load_data_in  out  1  one-cycle pulse; SPI_DATA_IN_I is valid that cycle
SPI_DATA_IN_I  out  DATA_WIDTH  received word, right-justified, upper bits zero
busy  out  1  high while a transfer is active

Behaviour:
- Reset (synchronous, active-high; takes priority over everything): state=IDLE; MOSI=0; done=0; load_data_in=0; busy=0; SPI_DATA_IN_I=0; tx/rx shift registers, counter, sck_q and load_q all 0. Reset mid-transfer aborts it with no done pulse.
- Edge detect: sck_q<=SCK_inter each cycle.
  - rise = SCK_inter & ~sck_q
  - fall = ~SCK_inter & sck_q
  - Rise and fall are mutually exclusive by construction.
- Start: start = load_data & ~load_q, where load_q<=load_data. A level held high after completion never retriggers.
- N = 8*(SPI_DATA_LEN+1). N is latched at start; later changes to SPI_DATA_LEN are ignored until the next transfer.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE: busy=0. On start: tx<=NEW_SPI_DATA_OUT, cnt<=N, rx<=0, seen_rise<=0, MOSI<=NEW_SPI_DATA_OUT[N-1], then go to SHIFT. Start is ignored in any other state.
  - SHIFT: busy=1.
    - On rise: rx<={rx[DATA_WIDTH-2:0],MISO_s}, cnt<=cnt-1, seen_rise<=1. If cnt==1, go to FINISH.
    - On fall with seen_rise=1 and cnt!=0: tx<=tx<<1, MOSI<=tx[N-2] (the next bit, MSB-first within N). Falls before the first rise are ignored.
    - load_data low at any time in SHIFT aborts: go to IDLE, MOSI<=0, no done, SPI_DATA_IN_I unchanged.
  - FINISH (1 cycle): SPI_DATA_IN_I<=rx masked to N bits; done=1; load_data_in=1; busy=0; MOSI<=0; next state IDLE.
- Latency: done asserts exactly 1 clk_cpu cycle after the clk_cpu cycle in which the N-th rise is detected.
- The engine assumes each SCK_inter phase lasts at least 2 clk_cpu cycles; faster SCK is unsupported.
- Bit order is always MSB-first within N bits; LSB-first is produced upstream by word reflection.

Optional Feature:
SPI_MISO_SYNC_EN
- Defined: MISO passes through a 2-flop synchronizer, and the rise used for sampling is delayed by 2 cycles to stay aligned with it. Done latency increases by 2 cycles. Requires SCK phases of at least 3 clk_cpu cycles.
- Undefined: MISO_s=MISO, sampled directly on the rise cycle.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_LEN_8/16/24/32 codes
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FINISH=2'd2
  - function len_to_bits(code) returning N
- One natural sub-module: spi_edge_detect (sck_q register, rise/fall outputs, and the optional synchronizer plus delay line).

Test Plan:
- LEN=00, data 0x000000A5, MISO loopback from MOSI, 8 SCK periods -> MOSI bits 1,0,1,0,0,1,0,1; done pulse 1 cycle; SPI_DATA_IN_I=0x000000A5.
- LEN=11, data 0xDEADBEEF, MISO tied 1 -> 32 rises then done; SPI_DATA_IN_I=0xFFFFFFFF; busy high for the whole transfer.
- LEN=01, data 0x1234ABCD -> only 0xABCD is shifted (MOSI first bit=1); SPI_DATA_IN_I upper 16 bits=0.
- load_data held high 20 cycles past done -> no second transfer; busy stays 0.
- load_data dropped after 5 rises of an 8-bit transfer -> IDLE, MOSI=0, no done, SPI_DATA_IN_I unchanged; rst asserted mid-transfer -> all outputs 0 next cycle.
- SCK_inter idling high (inverted mode), LEN=00 -> the initial fall is ignored; the first MOSI bit is held until the first rise; received byte is correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: length codes, FSM state
// encodings and the length-code to bit-count helper.
package spi_pkg;

  localparam logic [1:0] SPI_LEN_8  = 2'b00;
  localparam logic [1:0] SPI_LEN_16 = 2'b01;
  localparam logic [1:0] SPI_LEN_24 = 2'b10;
  localparam logic [1:0] SPI_LEN_32 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // N = 8 * (code + 1); the largest result (32) still fits in 6 bits
  function automatic logic [5:0] len_to_bits(input logic [1:0] code);
    len_to_bits = {1'b0, code, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Serial-clock edge detector for the SPI shift engine. SCK_inter is treated
// as data sampled on clk_cpu. Optional macro SPI_MISO_SYNC_EN adds a 2-flop
// MISO synchronizer and delays the rise strobe by 2 cycles so that sampling
// stays aligned with the synchronized data.
module spi_edge_detect (
  input  logic clk_cpu,
  input  logic rst,
  input  logic SCK_inter,
  input  logic MISO,
  output logic sck_rise,
  output logic sck_fall,
  output logic miso_s
);

  logic sck_q;
  logic rise_raw;

  // Previous-cycle copy of the serial clock for edge detection
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= SCK_inter;
    end
  end

  assign rise_raw = SCK_inter & ~sck_q;
  assign sck_fall = ~SCK_inter & sck_q;

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_reg;
  logic [1:0] rise_dly_reg;

  // Synchronize MISO and delay the rise strobe by the same two cycles
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      miso_sync_reg <= 2'b00;
      rise_dly_reg  <= 2'b00;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], MISO};
      rise_dly_reg  <= {rise_dly_reg[0], rise_raw};
    end
  end

  assign miso_s   = miso_sync_reg[1];
  assign sck_rise = rise_dly_reg[1];
`else
  assign miso_s   = MISO;
  assign sck_rise = rise_raw;
`endif

endmodule

// File: rtl/spi_shift_engine.sv
// SPI shift stage: drives MOSI MSB-first within N bits, assembles MISO into
// a right-justified receive word and pulses done/load_data_in at the end.
// Optional macro SPI_MISO_SYNC_EN (see spi_edge_detect) adds MISO
// synchronization and 2 extra cycles of done latency.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  input  logic                  SCK_inter,
  input  logic                  load_data,
  input  logic [DATA_WIDTH-1:0] NEW_SPI_DATA_OUT,
  input  logic [1:0]            SPI_DATA_LEN,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  done,
  output logic                  load_data_in,
  output logic [DATA_WIDTH-1:0] SPI_DATA_IN_I,
  output logic                  busy
);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      n_reg;
  logic                  seen_rise_reg;
  logic                  load_q;

  logic                  sck_rise;
  logic                  sck_fall;
  logic                  miso_s;
  logic                  start;
  logic [CNT_W-1:0]      n_start;
  logic [DATA_WIDTH-1:0] tx_aligned;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_mask;

  spi_edge_detect u_edge (
    .clk_cpu   (clk_cpu),
    .rst       (rst),
    .SCK_inter (SCK_inter),
    .MISO      (MISO),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .miso_s    (miso_s)
  );

  assign start   = load_data & ~load_q;
  assign n_start = CNT_W'(len_to_bits(SPI_DATA_LEN));
  // The transmit word is left-aligned at start so the current bit is always
  // the register MSB, whatever N is.
  assign tx_aligned = NEW_SPI_DATA_OUT << (CNT_W'(DATA_WIDTH) - n_start);
  assign rx_next    = {rx_reg[DATA_WIDTH-2:0], miso_s};
  assign rx_mask    = ~({DATA_WIDTH{1'b1}} << n_reg);

  // Transfer FSM with registered outputs; done/load_data_in/result are
  // loaded on the N-th rise so they are visible during the FINISH cycle.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tx_reg        <= '0;
      rx_reg        <= '0;
      cnt_reg       <= '0;
      n_reg         <= '0;
      seen_rise_reg <= 1'b0;
      load_q        <= 1'b0;
      MOSI          <= 1'b0;
      done          <= 1'b0;
      load_data_in  <= 1'b0;
      SPI_DATA_IN_I <= '0;
      busy          <= 1'b0;
    end else begin
      load_q       <= load_data;
      done         <= 1'b0;
      load_data_in <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            tx_reg        <= tx_aligned;
            n_reg         <= n_start;
            cnt_reg       <= n_start;
            rx_reg        <= '0;
            seen_rise_reg <= 1'b0;
            MOSI          <= tx_aligned[DATA_WIDTH-1];
            busy          <= 1'b1;
            state_reg     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!load_data) begin
            state_reg <= ST_IDLE;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
          end else if (sck_rise) begin
            rx_reg        <= rx_next;
            cnt_reg       <= cnt_reg - CNT_W'(1);
            seen_rise_reg <= 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
              state_reg     <= ST_FINISH;
              SPI_DATA_IN_I <= rx_next & rx_mask;
              done          <= 1'b1;
              load_data_in  <= 1'b1;
              busy          <= 1'b0;
              MOSI          <= 1'b0;
            end
          end else if (sck_fall && seen_rise_reg && (cnt_reg != '0)) begin
            // Falls before the first rise are ignored so an idle-high SCK
            // does not skip the first bit.
            tx_reg <= tx_reg << 1;
            MOSI   <= tx_reg[DATA_WIDTH-2];
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
module tb_spi_shift_engine;

`ifdef SPI_MISO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic        SCK_inter = 1'b0;
  logic        load_data = 1'b0;
  logic [31:0] NEW_SPI_DATA_OUT = 32'h0;
  logic [1:0]  SPI_DATA_LEN = 2'b00;
  logic        MISO;
  logic        MOSI;
  logic        done;
  logic        load_data_in;
  logic [31:0] SPI_DATA_IN_I;
  logic        busy;

  logic loop_en = 1'b0;
  logic miso_val = 1'b0;
  assign MISO = loop_en ? MOSI : miso_val;

  spi_shift_engine #(.DATA_WIDTH(32), .CNT_W(6)) dut (
    .clk_cpu          (clk_cpu),
    .rst              (rst),
    .SCK_inter        (SCK_inter),
    .load_data        (load_data),
    .NEW_SPI_DATA_OUT (NEW_SPI_DATA_OUT),
    .SPI_DATA_LEN     (SPI_DATA_LEN),
    .MISO             (MISO),
    .MOSI             (MOSI),
    .done             (done),
    .load_data_in     (load_data_in),
    .SPI_DATA_IN_I    (SPI_DATA_IN_I),
    .busy             (busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  int cyc = 0;
  int done_total = 0;
  int ld_total = 0;
  int pair_err = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  logic [31:0] last_word = 32'h0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk_cpu) cyc <= cyc + 1;

  // Pulse monitor: counts done/load_data_in pulses and captures the result
  always @(negedge clk_cpu) begin
    if (done) begin
      done_total = done_total + 1;
      done_cyc   = cyc;
      last_word  = SPI_DATA_IN_I;
    end
    if (load_data_in) ld_total = ld_total + 1;
    if (done !== load_data_in) pair_err = pair_err + 1;
  end

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One transfer: start, then nsck SCK periods of 4+4 clk_cpu cycles
  task automatic do_xfer(input logic [31:0] data, input logic [1:0] len, input int nsck,
                         input logic idle_high, output logic [31:0] mosi_bits,
                         output int dd, output int ldd, output int busy_low);
    int d0;
    int l0;
    SCK_inter = idle_high;
    NEW_SPI_DATA_OUT = data;
    SPI_DATA_LEN = len;
    load_data = 1'b0;
    tick();
    tick();
    d0 = done_total;
    l0 = ld_total;
    mosi_bits = 32'h0;
    busy_low = 0;
    load_data = 1'b1;
    tick();
    if (idle_high) begin
      SCK_inter = 1'b0;
      @(negedge clk_cpu);
      if (!busy) busy_low++;
      repeat (4) tick();
    end
    for (int i = 0; i < nsck; i++) begin
      SCK_inter = 1'b1;
      @(negedge clk_cpu);
      mosi_bits = {mosi_bits[30:0], MOSI};
      if (!busy) busy_low++;
      rise_cyc = cyc;
      repeat (4) tick();
      SCK_inter = 1'b0;
      if (i != nsck - 1) begin
        @(negedge clk_cpu);
        if (!busy) busy_low++;
      end
      repeat (4) tick();
    end
    if (idle_high) SCK_inter = 1'b1;
    repeat (6) tick();
    dd = done_total - d0;
    ldd = ld_total - l0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  len;
    logic        idle_high;
    logic        loop;
    logic        miso_const;
    logic [31:0] exp_mosi;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] mb;
    int dd;
    int ldd;
    int blow;
    int nsck;
    int bh;

    vecs[0] = '{32'h000000A5, 2'b00, 1'b0, 1'b1, 1'b0, 32'h000000A5, 32'h000000A5};
    vecs[1] = '{32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF};
    vecs[2] = '{32'h1234ABCD, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000ABCD, 32'h0000ABCD};
    vecs[3] = '{32'hFFC35A3C, 2'b10, 1'b0, 1'b1, 1'b0, 32'h00C35A3C, 32'h00C35A3C};
    vecs[4] = '{32'h0000005A, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0000005A, 32'h0000005A};
    vecs[5] = '{32'h00000081, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000081, 32'h00000000};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk_cpu);
    chk("reset_mosi", {31'h0, MOSI}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_ld", {31'h0, load_data_in}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_word", SPI_DATA_IN_I, 32'h0);
    rst = 1'b0;
    tick();

    // Table-driven transfers
    for (int v = 0; v < 6; v++) begin
      loop_en = vecs[v].loop;
      miso_val = vecs[v].miso_const;
      nsck = 8 * (int'(vecs[v].len) + 1);
      do_xfer(vecs[v].data, vecs[v].len, nsck, vecs[v].idle_high, mb, dd, ldd, blow);
      $display("xfer %0d data=0x%08h len=%0d mosi=0x%08h word=0x%08h done=%0d lat=%0d",
               v, vecs[v].data, vecs[v].len, mb, last_word, dd, done_cyc - rise_cyc);
      chk($sformatf("v%0d_mosi", v), mb, vecs[v].exp_mosi);
      chk($sformatf("v%0d_word", v), last_word, vecs[v].exp_word);
      chk($sformatf("v%0d_done_cnt", v), dd, 1);
      chk($sformatf("v%0d_ld_cnt", v), ldd, 1);
      chk($sformatf("v%0d_latency", v), done_cyc - rise_cyc, LAT);
      chk($sformatf("v%0d_busy_low", v), blow, 0);
      load_data = 1'b0;
      tick();
      tick();
    end

    // load_data held high after done must not retrigger
    loop_en = 1'b1;
    do_xfer(32'h0000003C, 2'b00, 8, 1'b0, mb, dd, ldd, blow);
    chk("hold_first_done", dd, 1);
    dd = done_total;
    bh = 0;
    for (int k = 0; k < 20; k++) begin
      if (k % 4 == 0) SCK_inter = ~SCK_inter;
      @(negedge clk_cpu);
      if (busy) bh++;
      tick();
    end
    $display("hold: busy_cycles=%0d extra_done=%0d", bh, done_total - dd);
    chk("hold_busy", bh, 0);
    chk("hold_no_done", done_total - dd, 0);
    load_data = 1'b0;
    SCK_inter = 1'b0;
    repeat (4) tick();

    // Abort by dropping load_data after 5 rises of an 8-bit transfer
    do_xfer(32'h0000000F, 2'b00, 5, 1'b0, mb, dd, ldd, blow);
    @(negedge clk_cpu);
    chk("abort_pre_mosi", {31'h0, MOSI}, 32'h1);
    chk("abort_pre_busy", {31'h0, busy}, 32'h1);
    load_data = 1'b0;
    tick();
    @(negedge clk_cpu);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_mosi", {31'h0, MOSI}, 32'h0);
    dd = done_total;
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) SCK_inter = ~SCK_inter;
      tick();
    end
    $display("abort: extra_done=%0d word=0x%08h", done_total - dd, SPI_DATA_IN_I);
    chk("abort_no_done", done_total - dd + ldd, 0);
    chk("abort_word_kept", SPI_DATA_IN_I, 32'h0000003C);
    SCK_inter = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a transfer
    loop_en = 1'b0;
    miso_val = 1'b1;
    do_xfer(32'h000000FF, 2'b00, 3, 1'b0, mb, dd, ldd, blow);
    @(negedge clk_cpu);
    chk("rstmid_pre_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    @(negedge clk_cpu);
    chk("rstmid_mosi", {31'h0, MOSI}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_done", {31'h0, done}, 32'h0);
    chk("rstmid_ld", {31'h0, load_data_in}, 32'h0);
    chk("rstmid_word", SPI_DATA_IN_I, 32'h0);
    rst = 1'b0;
    load_data = 1'b0;
    dd = done_total;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) SCK_inter = ~SCK_inter;
      tick();
    end
    $display("reset_mid: extra_done=%0d busy=%0d", done_total - dd, busy);
    chk("rstmid_no_done", done_total - dd, 0);
    chk("pulse_pairing", pair_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
